// File: rtl/mano_mem_arbiter.sv
// mano_mem_arbiter: shares single-port main memory between the CPU (C) and loader (L) with burst fairness and CPU lock
module mano_mem_arbiter #(
  parameter int AW        = 12,
  parameter int DW        = 16,
  parameter int MEM_DEPTH = 4066,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run_code,
  input  logic          c_req,
  input  logic          c_we,
  input  logic          c_lock,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [DW-1:0] l_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          addr_err
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam logic [1:0] O_NONE = 2'd0, O_C = 2'd1, O_L = 2'd2;
  logic [1:0]    owner;
  logic [BW-1:0] burst_cnt, burst_inc;
  logic          c_el, l_el, at_limit, pick_c, c_oor, l_oor, sel_oor, c_pend, l_pend;
  assign c_el      = rst_n && c_req && run_code;
  assign l_el      = rst_n && l_req;
  assign at_limit  = burst_cnt >= BW'(MAX_BURST);
  assign burst_inc = at_limit ? burst_cnt : burst_cnt + BW'(1);
  assign c_oor     = 32'(c_addr) >= MEM_DEPTH;
  assign l_oor     = 32'(l_addr) >= MEM_DEPTH;
  // tie-break only matters when both ports are eligible
  always_comb begin
    pick_c    = (owner == O_C && c_lock) || owner == O_NONE ? 1'b1 :
                owner == O_C ? !at_limit : at_limit;
    c_gnt     = c_el && (!l_el || pick_c);
    l_gnt     = l_el && !c_gnt;
    sel_oor   = c_gnt ? c_oor : l_oor;
    mem_en    = c_gnt || l_gnt;
    mem_we    = c_gnt ? c_we && !c_oor : l_gnt ? l_we && !l_oor : 1'b0;
    mem_addr  = c_gnt ? c_addr : l_gnt ? l_addr : '0;
    mem_wdata = c_gnt ? c_wdata : l_gnt ? l_wdata : '0;
    c_rvalid  = c_pend;
    l_rvalid  = l_pend;
    c_rdata   = c_pend && !addr_err ? mem_rdata : '0;
    l_rdata   = l_pend && !addr_err ? mem_rdata : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      owner     <= O_NONE;
      burst_cnt <= '0;
      c_pend    <= 1'b0;
      l_pend    <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      owner     <= c_gnt ? O_C : l_gnt ? O_L : O_NONE;
      burst_cnt <= c_gnt ? (owner == O_C ? burst_inc : BW'(1)) :
                   l_gnt ? (owner == O_L ? burst_inc : BW'(1)) : '0;
      c_pend    <= c_gnt && !c_we;
      l_pend    <= l_gnt && !l_we;
      addr_err  <= mem_en && sel_oor;
    end
endmodule

// File: tb/tb_mano_mem_arbiter.sv
// tb_mano_mem_arbiter: directed checks of grant order, lock, read routing, range errors and reset
module tb_mano_mem_arbiter;
  logic        clk = 0, rst_n = 0, run_code = 0;
  logic        c_req = 0, c_we = 0, c_lock = 0, l_req = 0, l_we = 0;
  logic [11:0] c_addr = 0, l_addr = 0, mem_addr;
  logic [15:0] c_wdata = 0, l_wdata = 0, c_rdata, l_rdata, mem_wdata, mem_rdata;
  logic        c_gnt, c_rvalid, l_gnt, l_rvalid, mem_en, mem_we, addr_err;
  logic [15:0] mem [0:4095];
  int          vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= mem[mem_addr];
  end
  mano_mem_arbiter dut (
    .clk(clk), .rst_n(rst_n), .run_code(run_code),
    .c_req(c_req), .c_we(c_we), .c_lock(c_lock), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .addr_err(addr_err));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    @(negedge clk);
    c_req = 0; l_req = 0; c_we = 0; l_we = 0; c_lock = 0;
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i);
    mem[12'hFE2] = 16'hBEEF;
    mem[12'hFFF] = 16'h1234;
    mem[12'h020] = 16'h5555;
    mem_rdata = 0;
    c_req = 1; run_code = 1;
    #2;
    chk("rst_c_gnt", c_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_c_rvalid", c_rvalid, 0);
    chk("rst_l_rvalid", l_rvalid, 0);
    chk("rst_addr_err", addr_err, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1; c_req = 0; run_code = 0;
    // 1: load mode, write then read back
    @(negedge clk);
    c_req = 1; l_req = 1; l_we = 1; l_addr = 12'h100; l_wdata = 16'h7001;
    #1;
    chk("t1_wr_l_gnt", l_gnt, 1);
    chk("t1_wr_c_gnt", c_gnt, 0);
    chk("t1_wr_mem_we", mem_we, 1);
    chk("t1_wr_mem_addr", mem_addr, 12'h100);
    edge1();
    chk("t1_wr_no_rvalid", l_rvalid, 0);
    @(negedge clk);
    l_we = 0;
    #1;
    chk("t1_rd_l_gnt", l_gnt, 1);
    chk("t1_rd_c_gnt", c_gnt, 0);
    edge1();
    chk("t1_l_rvalid", l_rvalid, 1);
    chk("t1_l_rdata", l_rdata, 16'h7001);
    chk("t1_c_rvalid", c_rvalid, 0);
    idle();
    edge1();
    // 2: fair bursts C,C,C,C,L,L,L,L,C
    @(negedge clk);
    run_code = 1; c_req = 1; l_req = 1; c_addr = 12'h010; l_addr = 12'h011;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk($sformatf("t2_c_gnt%0d", i), c_gnt, (i < 4 || i == 8));
      chk($sformatf("t2_l_gnt%0d", i), l_gnt, (i >= 4 && i < 8));
      edge1();
      chk($sformatf("t2_c_rv%0d", i), c_rvalid, (i < 4 || i == 8));
      chk($sformatf("t2_l_rv%0d", i), l_rvalid, (i >= 4 && i < 8));
      if (i < 4) chk($sformatf("t2_c_rd%0d", i), c_rdata, 16'h0010);
      @(negedge clk);
    end
    idle();
    edge1();
    // 3: lock overrides the burst limit
    @(negedge clk);
    c_req = 1; c_lock = 1; l_req = 1;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("t3_lock_c%0d", i), c_gnt, 1);
      chk($sformatf("t3_lock_l%0d", i), l_gnt, 0);
      edge1();
      @(negedge clk);
    end
    c_lock = 0;
    #1;
    chk("t3_unlock_l", l_gnt, 1);
    chk("t3_unlock_c", c_gnt, 0);
    idle();
    edge1();
    // 4: out-of-range read and write
    @(negedge clk);
    c_req = 1; c_we = 0; c_addr = 12'hFE2;
    #1;
    chk("t4_rd_gnt", c_gnt, 1);
    edge1();
    chk("t4_c_rvalid", c_rvalid, 1);
    chk("t4_c_rdata", c_rdata, 0);
    chk("t4_addr_err", addr_err, 1);
    @(negedge clk);
    c_we = 1; c_addr = 12'hFFF; c_wdata = 16'hAAAA;
    #1;
    chk("t4_wr_gnt", c_gnt, 1);
    chk("t4_wr_mem_we", mem_we, 0);
    edge1();
    chk("t4_wr_addr_err", addr_err, 1);
    chk("t4_mem_fff", mem[12'hFFF], 16'h1234);
    idle();
    edge1();
    chk("t4_err_clear", addr_err, 0);
    // 5: reset drops the pending read
    @(negedge clk);
    c_req = 1; c_addr = 12'h020;
    edge1();
    chk("t5_pre_rvalid", c_rvalid, 1);
    rst_n = 0;
    #1;
    chk("t5_rst_rvalid", c_rvalid, 0);
    chk("t5_rst_gnt", c_gnt, 0);
    c_req = 0;
    @(negedge clk);
    rst_n = 1;
    edge1();
    chk("t5_post_rvalid", c_rvalid, 0);
    @(negedge clk);
    c_req = 1; l_req = 1; l_addr = 12'h021;
    #1;
    chk("t5_first_c_gnt", c_gnt, 1);
    chk("t5_first_l_gnt", l_gnt, 0);
    edge1();
    chk("t5_c_rdata", c_rdata, 16'h5555);
    idle();
    edge1();
    // 6: alternating uncontended reads route to the issuer only
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      c_req = (i % 2 == 0); l_req = (i % 2 == 1);
      c_addr = 12'h100; l_addr = 12'h020;
      #1;
      chk($sformatf("t6_gnt%0d", i), (i % 2 == 0) ? c_gnt : l_gnt, 1);
      edge1();
      chk($sformatf("t6_c_rv%0d", i), c_rvalid, (i % 2 == 0));
      chk($sformatf("t6_l_rv%0d", i), l_rvalid, (i % 2 == 1));
      chk($sformatf("t6_c_rd%0d", i), c_rdata, (i % 2 == 0) ? 16'h7001 : 16'h0);
      chk($sformatf("t6_l_rd%0d", i), l_rdata, (i % 2 == 1) ? 16'h5555 : 16'h0);
    end
    idle();
    edge1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
